// File: rtl/ibex_pkg.sv
// Shared LSU types: access size, FSM states and byte-lane helpers.
package ibex_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_type_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_A  = 3'd1,
        WAIT_A = 3'd2,
        REQ_B  = 3'd3,
        WAIT_B = 3'd4
    } lsu_fsm_e;

    // The unused size encoding behaves as a word access.
    function automatic lsu_type_e lsu_type_norm(input logic [1:0] t);
        return (t == 2'b11) ? LSU_WORD : lsu_type_e'(t);
    endfunction

    function automatic logic lsu_misaligned(input lsu_type_e t,
                                            input logic [1:0] off);
        unique case (t)
            LSU_WORD: return off != 2'b00;
            LSU_HALF: return off == 2'b11;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_be_a(input lsu_type_e t,
                                            input logic [1:0] off);
        unique case (t)
            LSU_WORD: return 4'b1111 << off;
            LSU_HALF: return 4'b0011 << off;
            default:  return 4'b0001 << off;
        endcase
    endfunction

    function automatic logic [3:0] lsu_be_b(input lsu_type_e t,
                                            input logic [1:0] off);
        unique case (t)
            LSU_WORD: return 4'b1111 >> (3'd4 - {1'b0, off});
            default:  return 4'b0001;
        endcase
    endfunction

    function automatic logic [31:0] lsu_rotl(input logic [31:0] d,
                                             input logic [1:0] off);
        unique case (off)
            2'd0:    return d;
            2'd1:    return {d[23:0], d[31:24]};
            2'd2:    return {d[15:0], d[31:16]};
            default: return {d[7:0], d[31:8]};
        endcase
    endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Load data merge, byte shift and zero/sign extension.
module ibex_lsu_rdata_align
    import ibex_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] rdata_q,
    input  logic [1:0]  off,
    input  lsu_type_e   lsu_type,
    input  logic        sign_ext,
    input  logic        misaligned,
    output logic [31:0] data
);

    logic [63:0] merged;
    logic [31:0] shifted;

    assign merged  = misaligned ? {rdata, rdata_q} : {32'h0, rdata};
    assign shifted = 32'(merged >> {off, 3'b000});

    always_comb begin
        unique case (lsu_type)
            LSU_HALF: data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            LSU_BYTE: data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            default:  data = shifted;
        endcase
    end

endmodule

// File: rtl/ibex_lsu_lite.sv
// Single-outstanding load/store unit; split of misaligned accesses
// into two word transactions is enabled by IBEX_LSU_MISALIGNED_EN.
module ibex_lsu_lite
    import ibex_pkg::*;
#(
    parameter bit ResetAll             = 1'b0,
    parameter bit MisalignedSplitLatch = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    output logic        lsu_req_ready_o,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        busy_o
);

    lsu_fsm_e    state_q;
    lsu_type_e   type_q;
    logic        we_q;
    logic        sign_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic        rf_we_q;
    logic [31:0] rf_wdata_q;

    logic [1:0]  off;
    logic [31:0] addr_a;
    logic [31:0] load_data;
    logic        misaligned;
    logic        accept;
    logic        req_b;
    logic        bus_req;
    logic        done;
    logic        done_err;
    logic        capture_a;
    logic        load_ok;

    assign off        = addr_q[1:0];
    assign addr_a     = {addr_q[31:2], 2'b00};
    assign misaligned = lsu_misaligned(type_q, off);
    assign accept     = (state_q == IDLE) & lsu_req_i;

`ifdef IBEX_LSU_MISALIGNED_EN
    assign req_b   = (state_q == REQ_B);
    assign bus_req = (state_q == REQ_A) | req_b;
`else
    assign req_b   = 1'b0;
    assign bus_req = (state_q == REQ_A) & ~misaligned;
`endif

    // Bus fields are forced to zero whenever no request is raised.
    assign data_req_o   = bus_req;
    assign data_we_o    = bus_req & we_q;
    assign data_addr_o  = bus_req ? (req_b ? addr_a + 32'd4 : addr_a) : '0;
    assign data_be_o    = bus_req ? (req_b ? lsu_be_b(type_q, off)
                                           : lsu_be_a(type_q, off)) : '0;
    assign data_wdata_o = bus_req ? lsu_rotl(wdata_q, off) : '0;

    always_comb begin
        done      = 1'b0;
        done_err  = 1'b0;
        capture_a = 1'b0;
        unique case (state_q)
`ifndef IBEX_LSU_MISALIGNED_EN
            REQ_A: begin
                done     = misaligned;
                done_err = misaligned;
            end
`endif
            WAIT_A: begin
                if (data_rvalid_i) begin
`ifdef IBEX_LSU_MISALIGNED_EN
                    capture_a = misaligned;
                    done      = ~misaligned;
`else
                    done      = 1'b1;
`endif
                    done_err  = data_err_i;
                end
            end
`ifdef IBEX_LSU_MISALIGNED_EN
            WAIT_B: begin
                done     = data_rvalid_i;
                done_err = err_q | data_err_i;
            end
`endif
            default: ;
        endcase
    end

    assign load_ok = done & ~we_q & ~done_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            type_q       <= LSU_WORD;
            we_q         <= 1'b0;
            sign_q       <= 1'b0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_wdata_q   <= '0;
        end else begin
            resp_valid_q <= done;
            resp_err_q   <= done & done_err;
            rf_we_q      <= load_ok;
            rf_wdata_q   <= load_ok ? load_data : '0;
            unique case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        state_q <= REQ_A;
                        we_q    <= lsu_we_i;
                        type_q  <= lsu_type_norm(lsu_type_i);
                        sign_q  <= lsu_sign_ext_i;
                        err_q   <= 1'b0;
                    end
                end
                REQ_A: begin
                    if (done) state_q <= IDLE;
                    else if (data_gnt_i) state_q <= WAIT_A;
                end
                WAIT_A: begin
                    if (done) begin
                        state_q <= IDLE;
                    end else if (capture_a) begin
                        state_q <= REQ_B;
                        err_q   <= data_err_i;
                    end
                end
`ifdef IBEX_LSU_MISALIGNED_EN
                REQ_B: begin
                    if (data_gnt_i) state_q <= WAIT_B;
                end
                WAIT_B: begin
                    if (done) state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (ResetAll && rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= lsu_addr_i;
                wdata_q <= lsu_wdata_i;
            end
            if (capture_a && MisalignedSplitLatch) rdata_q <= data_rdata_i;
        end
    end

    ibex_lsu_rdata_align u_align (
        .rdata      (data_rdata_i),
        .rdata_q    (rdata_q),
        .off        (off),
        .lsu_type   (type_q),
        .sign_ext   (sign_q),
        .misaligned (misaligned),
        .data       (load_data)
    );

    assign lsu_req_ready_o  = (state_q == IDLE);
    assign busy_o           = ~lsu_req_ready_o;
    assign lsu_resp_valid_o = resp_valid_q;
    assign lsu_resp_err_o   = resp_err_q;
    assign rf_we_lsu_o      = rf_we_q;
    assign rf_wdata_lsu_o   = rf_wdata_q;

endmodule

// File: tb/tb_ibex_lsu_lite.sv
// Scoreboard bench for ibex_lsu_lite with a byte-lane reference model.
module tb_ibex_lsu_lite;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_req_ready_o;
    logic        lsu_we_i = 1'b0;
    logic [1:0]  lsu_type_i = 2'b00;
    logic        lsu_sign_ext_i = 1'b0;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i = 1'b0;
    logic        data_err_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic [31:0] rf_wdata_lsu_o;
    logic        rf_we_lsu_o;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_err_o;
    logic        busy_o;

    ibex_lsu_lite dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .lsu_req_i        (lsu_req_i),
        .lsu_req_ready_o  (lsu_req_ready_o),
        .lsu_we_i         (lsu_we_i),
        .lsu_type_i       (lsu_type_i),
        .lsu_sign_ext_i   (lsu_sign_ext_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_addr_o      (data_addr_o),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_wdata_o     (data_wdata_o),
        .data_rvalid_i    (data_rvalid_i),
        .data_err_i       (data_err_i),
        .data_rdata_i     (data_rdata_i),
        .rf_wdata_lsu_o   (rf_wdata_lsu_o),
        .rf_we_lsu_o      (rf_we_lsu_o),
        .lsu_resp_valid_o (lsu_resp_valid_o),
        .lsu_resp_err_o   (lsu_resp_err_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          stall;
        int          rv_dly;
    } bus_t;

    typedef struct {
        logic        err;
        logic        rf_we;
        logic [31:0] rf_wdata;
    } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory side: grants after the entry's stall, answers rv_dly later.
    bus_t cur;
    int   pend_cnt = 0;
    int   stall_cnt = 0;
    bit   stalling = 1'b0;

    always @(negedge clk_i) begin
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = 32'hA5A5_5A5A;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = cur.rdata;
                data_err_i    = cur.err;
            end
        end else if (data_req_o) begin
            if (exp_bus.size() == 0) begin
                check("bus_unexp", 32'(data_req_o), 32'd0);
                cur.rdata  = '0;
                cur.err    = 1'b1;
                data_gnt_i = 1'b1;
                pend_cnt   = 1;
            end else begin
                if (!stalling) begin
                    stall_cnt = exp_bus[0].stall;
                    stalling  = 1'b1;
                end
                if (stall_cnt > 0) begin
                    stall_cnt--;
                    data_rvalid_i = 1'b1;
                    data_err_i    = 1'b1;
                    data_rdata_i  = 32'hBAD0_BAD0;
                end else begin
                    cur      = exp_bus.pop_front();
                    stalling = 1'b0;
                    check("bus_addr", data_addr_o, cur.addr);
                    check("bus_be", 32'(data_be_o), 32'(cur.be));
                    check("bus_we", 32'(data_we_o), 32'(cur.we));
                    check("bus_wdata", data_wdata_o, cur.wdata);
                    data_gnt_i = 1'b1;
                    pend_cnt   = cur.rv_dly;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        rsp_t r;
        if (lsu_resp_valid_o) begin
            if (exp_rsp.size() == 0) begin
                check("resp_unexp", 32'(lsu_resp_valid_o), 32'd0);
            end else begin
                r = exp_rsp.pop_front();
                check("resp_err", 32'(lsu_resp_err_o), 32'(r.err));
                check("rf_we", 32'(rf_we_lsu_o), 32'(r.rf_we));
                check("rf_wdata", rf_wdata_lsu_o, r.rf_wdata);
            end
        end else if (rf_we_lsu_o || lsu_resp_err_o) begin
            check("stray_rf_we", 32'(rf_we_lsu_o), 32'd0);
        end
    end

    task automatic run_access(input logic we, input logic [1:0] typ,
                              input logic sgn, input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input logic [31:0] rd_a,
                              input logic [31:0] rd_b,
                              input logic err_a, input logic err_b,
                              input int stall, input int lat);
        int          off, size, lane, n;
        logic [3:0]  be_a, be_b;
        logic [31:0] val, rot;
        logic        mis, err, bus_on, rfwe;
        bus_t        t;
        rsp_t        r;
        off  = int'(addr[1:0]);
        size = (typ == 2'b01) ? 2 : (typ == 2'b10) ? 1 : 4;
        be_a = '0;
        be_b = '0;
        val  = '0;
        rot  = '0;
        for (int i = 0; i < size; i++) begin
            lane = off + i;
            if (lane < 4) begin
                be_a[lane]    = 1'b1;
                val[i*8 +: 8] = rd_a[lane*8 +: 8];
            end else begin
                be_b[lane-4]  = 1'b1;
                val[i*8 +: 8] = rd_b[(lane-4)*8 +: 8];
            end
        end
        if (sgn && size == 1 && val[7]) val[31:8] = '1;
        if (sgn && size == 2 && val[15]) val[31:16] = '1;
        for (int i = 0; i < 4; i++) rot[((i+off)%4)*8 +: 8] = wdata[i*8 +: 8];
        mis    = (be_b != 4'b0000);
        err    = err_a | (mis & err_b);
        bus_on = 1'b1;
`ifndef IBEX_LSU_MISALIGNED_EN
        if (mis) begin
            bus_on = 1'b0;
            err    = 1'b1;
        end
`endif
        if (bus_on) begin
            t.addr   = {addr[31:2], 2'b00};
            t.be     = be_a;
            t.we     = we;
            t.wdata  = rot;
            t.rdata  = rd_a;
            t.err    = err_a;
            t.stall  = stall;
            t.rv_dly = 1 + (stall % 3);
            exp_bus.push_back(t);
            if (mis) begin
                t.addr  = {addr[31:2], 2'b00} + 32'd4;
                t.be    = be_b;
                t.rdata = rd_b;
                t.err   = err_b;
                exp_bus.push_back(t);
            end
        end
        rfwe       = ~we & ~err;
        r.err      = err;
        r.rf_we    = rfwe;
        r.rf_wdata = rfwe ? val : 32'h0;
        exp_rsp.push_back(r);

        check("ready_idle", 32'(lsu_req_ready_o), 32'd1);
        lsu_req_i      = 1'b1;
        lsu_we_i       = we;
        lsu_type_i     = typ;
        lsu_sign_ext_i = sgn;
        lsu_addr_i     = addr;
        lsu_wdata_i    = wdata;
        @(posedge clk_i);
        @(negedge clk_i);
        lsu_req_i   = 1'b0;
        lsu_we_i    = 1'($urandom_range(0, 1));
        lsu_addr_i  = $urandom;
        lsu_wdata_i = $urandom;
        check("busy", 32'(busy_o), 32'd1);
        n = 1;
        while (!lsu_resp_valid_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        check("resp_seen", 32'(lsu_resp_valid_o), 32'd1);
        if (lat > 0) check("latency", 32'(n), 32'(lat));
        check("ready_done", 32'(lsu_req_ready_o), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t        t;
        logic        r_we, r_sgn, r_ea, r_eb;
        logic [1:0]  r_typ;
        logic [31:0] r_addr;

        repeat (3) @(negedge clk_i);
        check("rst_ready", 32'(lsu_req_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_req", 32'(data_req_o), 32'd0);
        check("rst_resp", 32'(lsu_resp_valid_o), 32'd0);
        check("rst_rf_we", 32'(rf_we_lsu_o), 32'd0);
        check("rst_rf_wdata", rf_wdata_lsu_o, 32'd0);
        check("rst_addr", data_addr_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0,
                   1'b0, 1'b0, 0, 3);
        run_access(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 32'h80123456, 32'h0,
                   1'b0, 1'b0, 0, 0);
        run_access(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'h80123456, 32'h0,
                   1'b0, 1'b0, 1, 0);
        run_access(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h11223344,
                   32'h55667788, 1'b0, 1'b0, 0, 0);
        run_access(1'b1, 2'b01, 1'b0, 32'h0FF, 32'h0000ABCD, 32'h0, 32'h0,
                   1'b0, 1'b0, 0, 0);
        run_access(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h11223344,
                   32'h55667788, 1'b1, 1'b0, 0, 0);
        run_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h8001_1234, 32'h0,
                   1'b0, 1'b0, 0, 0);
        run_access(1'b0, 2'b11, 1'b1, 32'h200, 32'h0, 32'h8765_4321, 32'h0,
                   1'b0, 1'b0, 0, 0);
        run_access(1'b1, 2'b00, 1'b0, 32'h104, 32'hCAFE_BABE, 32'h0, 32'h0,
                   1'b0, 1'b0, 2, 0);
        run_access(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'hFF9A_BCFF, 32'h0,
                   1'b0, 1'b0, 0, 0);
        run_access(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'hAABBCCDD,
                   32'h11223344, 1'b0, 1'b1, 1, 0);
        run_access(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 32'h1234_5678, 32'h0,
                   1'b1, 1'b0, 0, 0);

        for (int k = 0; k < 24; k++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_typ  = 2'($urandom_range(0, 3));
            r_sgn  = 1'($urandom_range(0, 1));
            r_ea   = ($urandom_range(0, 7) == 0);
            r_eb   = ($urandom_range(0, 7) == 0);
            r_addr = {20'h00001, 12'($urandom)};
            run_access(r_we, r_typ, r_sgn, r_addr, $urandom, $urandom,
                       $urandom, r_ea, r_eb, $urandom_range(0, 3), 0);
        end

        // Reset while waiting for part A; the late response must vanish.
        t.addr   = 32'h300;
        t.be     = 4'b1111;
        t.we     = 1'b0;
        t.wdata  = 32'h0;
        t.rdata  = 32'hCAFE_F00D;
        t.err    = 1'b0;
        t.stall  = 0;
        t.rv_dly = 2;
        exp_bus.push_back(t);
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_type_i  = 2'b00;
        lsu_addr_i  = 32'h300;
        lsu_wdata_i = 32'h0;
        @(posedge clk_i);
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        check("rstw_req", 32'(data_req_o), 32'd1);
        @(negedge clk_i);
        check("rstw_busy", 32'(busy_o), 32'd1);
        check("rstw_noreq", 32'(data_req_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rstw_ready", 32'(lsu_req_ready_o), 32'd1);
        check("rstw_resp0", 32'(lsu_resp_valid_o), 32'd0);
        @(negedge clk_i);
        check("rstw_resp1", 32'(lsu_resp_valid_o), 32'd0);
        check("rstw_rf_we", 32'(rf_we_lsu_o), 32'd0);
        check("rstw_idle", 32'(lsu_req_ready_o), 32'd1);
        check("rstw_noreq2", 32'(data_req_o), 32'd0);

        run_access(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 32'h0BAD_F00D, 32'h0,
                   1'b0, 1'b0, 0, 3);

        repeat (3) @(negedge clk_i);
        check("bus_left", 32'(exp_bus.size()), 32'd0);
        check("rsp_left", 32'(exp_rsp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
